// File: rtl/sin_dds_ctrl_if.sv
// Control and sample-stream bundle for the sine DDS front end.
// The slave modport is the DDS controller; the master modport is the surrounding system and ROM.
interface sin_dds_ctrl_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 7,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] freq_word;
  logic [ADDR_W-1:0]  phase_ofs;
  logic [CNT_W-1:0]   burst_len;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic [DATA_W-1:0]  wave_out;
  logic               wave_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, freq_word, phase_ofs, burst_len, rom_data,
    input  rom_addr, wave_out, wave_valid, busy, done
  );

  modport slave (
    input  start, stop, freq_word, phase_ofs, burst_len, rom_data,
    output rom_addr, wave_out, wave_valid, busy, done
  );
endinterface

// File: rtl/sin_dds_ctrl.sv
// Phase-accumulator DDS front end: drives the sine ROM address and re-registers
// the returned samples, tracking the ROM read latency with a flag pipeline.
module sin_dds_ctrl #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 7,
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  sin_dds_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fw_q, fw_d;
  logic [ADDR_W-1:0]  ofs_q, ofs_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               issue_q, issue_d;
  logic [ROM_LAT-1:0] lat_q, lat_d;
  logic [DATA_W-1:0]  wave_q, wave_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic [ROM_LAT-1:0] lat_rest;
  logic               lat_exit;
  logic               pending_rest;

  // issue_q marks the cycle rom_addr is presented; lat_q then counts the ROM's
  // own read latency so the exiting flag lines up with valid rom_data.
  assign lat_d[0] = issue_q;
  for (genvar gi = 1; gi < ROM_LAT; gi++) begin : g_lat
    assign lat_d[gi] = lat_q[gi-1];
  end

  assign cnt_inc  = cnt_q + 1'b1;
  assign lat_exit = lat_q[ROM_LAT-1];

  always_comb begin
    lat_rest = lat_q;
    lat_rest[ROM_LAT-1] = 1'b0;
  end

  assign pending_rest = issue_q || (lat_rest != '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fw_d    = fw_q;
    ofs_d   = ofs_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    issue_d = 1'b0;
    wave_d  = lat_exit ? bus.rom_data : wave_q;
    valid_d = lat_exit;
    // The final sample is the one leaving the pipeline with nothing behind it.
    done_d  = (state_q == ST_FLUSH) && lat_exit && !pending_rest;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          fw_d    = bus.freq_word;
          ofs_d   = bus.phase_ofs;
          len_d   = bus.burst_len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_FLUSH;
        end else begin
          addr_d  = acc_q[PHASE_W-1 -: ADDR_W] + ofs_q;
          acc_d   = acc_q + fw_q;
          cnt_d   = cnt_inc;
          issue_d = 1'b1;
          if ((len_q != '0) && (cnt_inc == len_q)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!issue_q && (lat_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      fw_q    <= '0;
      ofs_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      issue_q <= 1'b0;
      lat_q   <= '0;
      wave_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fw_q    <= fw_d;
      ofs_q   <= ofs_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      lat_q   <= lat_d;
      wave_q  <= wave_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.wave_out   = wave_q;
  assign bus.wave_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sin_dds_ctrl.sv
// Randomized scoreboard bench for sin_dds_ctrl: runs are predicted from phase
// arithmetic, and a negedge monitor checks every sample, its address and done.
module tb_sin_dds_ctrl;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 7;
  localparam int ROM_LAT = 1;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                first;
    bit                last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sb_off = 1'b0;
  exp_t exp_q[$];

  sin_dds_ctrl_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sin_dds_ctrl #(
    .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[6:0] ^ a[11:5];
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected sample for every wave_valid cycle.
  logic [ADDR_W-1:0] hist [0:3];
  bit                prev_valid = 1'b0;
  initial begin
    exp_t e;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.rom_addr;
      if (!sb_off && !rst) begin
        if (bus.wave_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_sample: got wave_out %0h expected no sample at %0t", bus.wave_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sample_addr", 32'(hist[ROM_LAT+1]), 32'(e.addr));
            chk("wave_out", 32'(bus.wave_out), 32'(rom_f(e.addr)));
            chk("done", 32'(bus.done), 32'(e.last));
            if (!e.first) chk("no_gap", 32'(prev_valid), 32'd1);
          end
        end else begin
          chk("done_idle", 32'(bus.done), 32'd0);
        end
      end
      prev_valid = bus.wave_valid;
    end
  end

  // One run: predicts the samples, then drives start / optional stop / ignored start.
  task automatic run(input logic [31:0] fw, input logic [11:0] ofs, input logic [15:0] len,
                     input int stop_after, input bit inject);
    int n;
    int cmax;
    int cyc;
    exp_t e;
    if (len != 0 && (stop_after < 0 || stop_after >= int'(len))) n = int'(len);
    else n = stop_after;
    for (int i = 0; i < n; i++) begin
      longint unsigned a;
      a = (longint'(i) * longint'(fw)) & 64'hFFFF_FFFF;
      e.addr  = 12'(((a >> (PHASE_W - ADDR_W)) + longint'(ofs)) & 64'hFFF);
      e.first = (i == 0);
      e.last  = (i == n - 1);
      exp_q.push_back(e);
    end
    bus.start = 1'b1; bus.freq_word = fw; bus.phase_ofs = ofs; bus.burst_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.freq_word = $urandom; bus.phase_ofs = 12'($urandom); bus.burst_len = 16'($urandom);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    cmax = (stop_after + 1 > 2) ? stop_after + 1 : 2;
    for (int c = 1; c <= cmax; c++) begin
      if (stop_after >= 0 && c == stop_after + 1) bus.stop = 1'b1;
      if (inject && c == 2) begin
        bus.start = 1'b1;
        bus.freq_word = $urandom;
      end
      @(posedge clk); #1;
      bus.stop = 1'b0;
      bus.start = 1'b0;
    end
    cyc = 0;
    while (bus.busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_timeout", 32'(bus.busy), 32'd0);
    chk("run_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int len;
    int sa;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.freq_word = '0; bus.phase_ofs = '0; bus.burst_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_wave_out", 32'(bus.wave_out), 32'd0);
    chk("rst_wave_valid", 32'(bus.wave_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(32'h0010_0000, 12'h000, 16'd8, -1, 1'b0);
    run(32'h8000_0000, 12'h7FF, 16'd4, -1, 1'b0);
    run(32'h0010_0000, 12'hFFE, 16'd4, -1, 1'b0);
    run(32'h0010_0000, 12'h000, 16'd0, 10, 1'b0);
    run(32'h0020_0000, 12'h005, 16'd6, -1, 1'b1);
    run(32'h0013_3000, 12'h123, 16'd0, 0, 1'b0);

    // start and stop together in IDLE: stop wins
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("start_stop_idle", 32'(bus.busy), 32'd0);

    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 12);
      if (len == 0) sa = $urandom_range(0, 15);
      else sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 2)) : -1;
      run($urandom, 12'($urandom), 16'(len), sa, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a continuous run
    sb_off = 1'b1;
    bus.start = 1'b1; bus.freq_word = 32'h0123_4567; bus.phase_ofs = 12'h321; bus.burst_len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("midrun_wave_out", 32'(bus.wave_out), 32'd0);
    chk("midrun_wave_valid", 32'(bus.wave_valid), 32'd0);
    chk("midrun_busy", 32'(bus.busy), 32'd0);
    chk("midrun_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    sb_off = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    run(32'h0010_0000, 12'h040, 16'd5, -1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
